self_clean_timer: RTL and testbench

//   Parametrised self-clean sequencer for the range-hood controller. Runs a configurable
//   MM:SS countdown from an internal clk-enable prescaler (no derived clocks) and reports

---
 rtl/self_clean_timer_if.sv | 26 ++
 rtl/self_clean_timer.sv | 163 ++++++++++++++++
 tb/tb_self_clean_timer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/self_clean_timer_if.sv
// Bundle of the self-clean timer control inputs and status outputs.
// The slave modport is the timer's view; master is the controller/bench view.
interface self_clean_timer_if #(
  parameter int TW = 13
);
  logic          i_is_on;
  logic          i_start_clean;
  logic          i_abort;
  logic          i_pause;
  logic          o_cleaning;
  logic          o_paused;
  logic [TW-1:0] o_remain_sec;
  logic [7:0]    o_cd_min_bcd;
  logic [7:0]    o_cd_sec_bcd;
  logic          o_done;

  modport master (
    output i_is_on, i_start_clean, i_abort, i_pause,
    input  o_cleaning, o_paused, o_remain_sec, o_cd_min_bcd, o_cd_sec_bcd, o_done
  );

  modport slave (
    input  i_is_on, i_start_clean, i_abort, i_pause,
    output o_cleaning, o_paused, o_remain_sec, o_cd_min_bcd, o_cd_sec_bcd, o_done
  );
endinterface

// File: rtl/self_clean_timer.sv
// Self-clean MM:SS countdown sequencer with clock-enable prescaler and BCD readout.
// Optional pause/hold support is enabled by defining SELF_CLEAN_PAUSE_EN.
module self_clean_timer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int CLEAN_SEC = 180,
  parameter int TW        = 13
) (
  input  logic               clk,
  input  logic               rst,
  self_clean_timer_if.slave  bus
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int MINS = CLEAN_SEC / 60;
  localparam int SECS = CLEAN_SEC % 60;
  localparam logic [7:0] MIN_BCD = {4'(MINS / 10), 4'(MINS % 10)};
  localparam logic [7:0] SEC_BCD = {4'(SECS / 10), 4'(SECS % 10)};

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CLEANING = 2'd1;
  localparam logic [1:0] S_PAUSED   = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]    r_state;
  logic [PW-1:0] r_presc;
  logic          r_start_q;
  logic          r_cleaning;
  logic          r_paused;
  logic          r_done;
  logic [TW-1:0] r_remain;
  logic [7:0]    r_min;
  logic [7:0]    r_sec;

  logic          w_start_edge;
  logic          w_cancel;
  logic          w_tick;
  logic          w_last;
  logic [7:0]    w_min_dec;
  logic [7:0]    w_sec_dec;

  assign w_start_edge = bus.i_start_clean & ~r_start_q;
  assign w_cancel     = bus.i_abort | ~bus.i_is_on;
  assign w_tick       = (r_presc == PW'(CLK_HZ - 1));
  assign w_last       = (r_remain == TW'(1));

`ifndef SELF_CLEAN_PAUSE_EN
  logic w_unused_pause;
  assign w_unused_pause = bus.i_pause;
`endif

  // Digit-wise BCD decrement with borrow, so no divider is needed at run time.
  always_comb begin
    w_sec_dec = r_sec;
    w_min_dec = r_min;
    if (r_sec == 8'h00) begin
      w_sec_dec = 8'h59;
      if (r_min[3:0] == 4'd0)
        w_min_dec = {r_min[7:4] - 4'd1, 4'd9};
      else
        w_min_dec = r_min - 8'd1;
    end else if (r_sec[3:0] == 4'd0) begin
      w_sec_dec = {r_sec[7:4] - 4'd1, 4'd9};
    end else begin
      w_sec_dec = r_sec - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_start_q  <= 1'b1;
      r_cleaning <= 1'b0;
      r_paused   <= 1'b0;
      r_done     <= 1'b0;
      r_remain   <= '0;
      r_min      <= 8'h00;
      r_sec      <= 8'h00;
    end else begin
      r_start_q <= bus.i_start_clean;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge && bus.i_is_on) begin
            r_state    <= S_CLEANING;
            r_presc    <= '0;
            r_cleaning <= 1'b1;
            r_remain   <= TW'(CLEAN_SEC);
            r_min      <= MIN_BCD;
            r_sec      <= SEC_BCD;
          end
        end
        S_CLEANING: begin
          if (w_cancel) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_cleaning <= 1'b0;
            r_paused   <= 1'b0;
            r_remain   <= '0;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
          end else begin
            if (w_tick) begin
              r_presc  <= '0;
              r_remain <= r_remain - TW'(1);
              r_min    <= w_min_dec;
              r_sec    <= w_sec_dec;
              if (w_last) begin
                r_state    <= S_DONE;
                r_cleaning <= 1'b0;
                r_done     <= 1'b1;
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
`ifdef SELF_CLEAN_PAUSE_EN
            // The tick of this cycle has been applied; only then do we hold.
            if (bus.i_pause && !(w_tick && w_last)) begin
              r_state  <= S_PAUSED;
              r_paused <= 1'b1;
            end
`endif
          end
        end
        S_PAUSED: begin
          if (w_cancel) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_cleaning <= 1'b0;
            r_paused   <= 1'b0;
            r_remain   <= '0;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
`ifdef SELF_CLEAN_PAUSE_EN
          end else if (!bus.i_pause) begin
            r_state  <= S_CLEANING;
            r_paused <= 1'b0;
          end
`else
          end else begin
            r_state  <= S_CLEANING;
            r_paused <= 1'b0;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_cleaning   = r_cleaning;
  assign bus.o_paused     = r_paused;
  assign bus.o_done       = r_done;
  assign bus.o_remain_sec = r_remain;
  assign bus.o_cd_min_bcd = r_min;
  assign bus.o_cd_sec_bcd = r_sec;

endmodule

// File: tb/tb_self_clean_timer.sv
// Table-driven bench for self_clean_timer (CLK_HZ=4, CLEAN_SEC=65) with a scoreboard
// queue; expectations adapt to whether SELF_CLEAN_PAUSE_EN is defined.
module tb_self_clean_timer;

  localparam int CLK_HZ    = 4;
  localparam int CLEAN_SEC = 65;
  localparam int TW        = 13;

`ifdef SELF_CLEAN_PAUSE_EN
  localparam int PX  = 10;
  localparam bit PON = 1'b1;
`else
  localparam int PX  = 0;
  localparam bit PON = 1'b0;
`endif

  typedef struct {
    string      name;
    bit         rst;
    bit         on;
    bit         st;
    bit         ab;
    bit         pa;
    int         hold;
    bit         cl;
    bit         pd;
    bit         dn;
    int         rem;
    logic [7:0] mb;
    logic [7:0] sb;
  } vec_t;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFails;
  vec_t vecs[$];
  vec_t expQ[$];

  self_clean_timer_if #(.TW(TW)) bus ();

  self_clean_timer #(
    .CLK_HZ(CLK_HZ),
    .CLEAN_SEC(CLEAN_SEC),
    .TW(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, bit r, bit on, bit st, bit ab, bit pa, int hold,
                              bit cl, bit pd, bit dn, int rem, logic [7:0] mb, logic [7:0] sb);
    vec_t v;
    v.name = n; v.rst = r; v.on = on; v.st = st; v.ab = ab; v.pa = pa; v.hold = hold;
    v.cl = cl; v.pd = pd; v.dn = dn; v.rem = rem; v.mb = mb; v.sb = sb;
    return v;
  endfunction

  // Independent binary-to-MM:SS BCD reference used by the hand-written run.
  function automatic logic [15:0] toBcd(int s);
    int m;
    int sec;
    m   = s / 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst               = v.rst;
    bus.i_is_on       = v.on;
    bus.i_start_clean = v.st;
    bus.i_abort       = v.ab;
    bus.i_pause       = v.pa;
    expQ.push_back(v);
    repeat (v.hold) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    vec_t e;
    if (expQ.size() == 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = expQ.pop_front();
    cmp({e.name, ".cleaning"}, 32'(bus.o_cleaning), 32'(e.cl));
    cmp({e.name, ".paused"},   32'(bus.o_paused),   32'(e.pd));
    cmp({e.name, ".done"},     32'(bus.o_done),     32'(e.dn));
    cmp({e.name, ".remain"},   32'(bus.o_remain_sec), 32'(e.rem));
    cmp({e.name, ".min_bcd"},  32'(bus.o_cd_min_bcd), 32'(e.mb));
    cmp({e.name, ".sec_bcd"},  32'(bus.o_cd_sec_bcd), 32'(e.sb));
  endtask

  initial begin
    logic [15:0] bcd;
    nChecks = 0;
    nFails  = 0;
    rst = 1'b1;
    bus.i_is_on = 1'b1;
    bus.i_start_clean = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_pause = 1'b0;

    //                 name            rst on st ab pa hold  cl pd dn rem  min    sec
    vecs.push_back(mk("rst",           1, 1, 0, 0, 0,   2,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("idle",          0, 1, 0, 0, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t1_entry",      0, 1, 1, 0, 0,   1,  1, 0, 0, 65, 8'h01, 8'h05));
    vecs.push_back(mk("t1_pre",        0, 1, 0, 0, 0,   3,  1, 0, 0, 65, 8'h01, 8'h05));
    vecs.push_back(mk("t1_tick1",      0, 1, 0, 0, 0,   1,  1, 0, 0, 64, 8'h01, 8'h04));
    vecs.push_back(mk("t1_six",        0, 1, 0, 0, 0,  20,  1, 0, 0, 59, 8'h00, 8'h59));
    vecs.push_back(mk("t1_last",       0, 1, 0, 0, 0, 235,  1, 0, 0,  1, 8'h00, 8'h01));
    vecs.push_back(mk("t1_done",       0, 1, 0, 0, 0,   1,  0, 0, 1,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t1_idle",       0, 1, 0, 0, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t2_off_start",  0, 0, 1, 0, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t2_rearm",      0, 1, 0, 0, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t2_entry",      0, 1, 1, 0, 0,   1,  1, 0, 0, 65, 8'h01, 8'h05));
    vecs.push_back(mk("t2_r30",        0, 1, 0, 0, 0, 140,  1, 0, 0, 30, 8'h00, 8'h30));
    vecs.push_back(mk("t2_pwroff",     0, 0, 0, 0, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t2_nodone",     0, 1, 0, 0, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t3_entry",      0, 1, 1, 0, 0,   1,  1, 0, 0, 65, 8'h01, 8'h05));
    vecs.push_back(mk("t3_last",       0, 1, 0, 0, 0, 259,  1, 0, 0,  1, 8'h00, 8'h01));
    vecs.push_back(mk("t3_abort",      0, 1, 0, 1, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t3_nodone",     0, 1, 0, 0, 0,   2,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t4_rsthold",    1, 1, 1, 0, 0,   2,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t4_release",    0, 1, 1, 0, 0,   3,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t4_rearm",      0, 1, 0, 0, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t4_entry",      0, 1, 1, 0, 0,   1,  1, 0, 0, 65, 8'h01, 8'h05));
    vecs.push_back(mk("t4_r50",        0, 1, 0, 0, 0,  60,  1, 0, 0, 50, 8'h00, 8'h50));
    vecs.push_back(mk("t4_repulse",    0, 1, 1, 0, 0,   1,  1, 0, 0, 50, 8'h00, 8'h50));
    vecs.push_back(mk("t4_noreload",   0, 1, 0, 0, 0,   3,  1, 0, 0, 49, 8'h00, 8'h49));
    vecs.push_back(mk("t4_abort",      0, 1, 0, 1, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t6_entry",      0, 1, 1, 0, 0,   1,  1, 0, 0, 65, 8'h01, 8'h05));
    vecs.push_back(mk("t6_r20",        0, 1, 0, 0, 0, 180,  1, 0, 0, 20, 8'h00, 8'h20));
    vecs.push_back(mk("t6_rst",        1, 1, 0, 0, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t6_rearm",      0, 1, 0, 0, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t6_entry2",     0, 1, 1, 0, 0,   1,  1, 0, 0, 65, 8'h01, 8'h05));
    vecs.push_back(mk("t6_last",       0, 1, 0, 0, 0, 259,  1, 0, 0,  1, 8'h00, 8'h01));
    vecs.push_back(mk("t6_done",       0, 1, 0, 0, 0,   1,  0, 0, 1,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t6_idle",       0, 1, 0, 0, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t5_entry",      0, 1, 1, 0, 0,   1,  1, 0, 0, 65, 8'h01, 8'h05));
    vecs.push_back(mk("t5_r40p2",      0, 1, 0, 0, 0, 102,  1, 0, 0, 40, 8'h00, 8'h40));
    vecs.push_back(mk("t5_pause",      0, 1, 0, 0, 1,  10,  1, PON, 0, PON ? 40 : 37,
                      8'h00, PON ? 8'h40 : 8'h37));
    vecs.push_back(mk("t5_resume",     0, 1, 0, 0, 0,   1,  1, 0, 0, PON ? 40 : 37,
                      8'h00, PON ? 8'h40 : 8'h37));
    vecs.push_back(mk("t5_last",       0, 1, 0, 0, 0, 146 + PX, 1, 0, 0, 1, 8'h00, 8'h01));
    vecs.push_back(mk("t5_done",       0, 1, 0, 0, 0,   1,  0, 0, 1,  0, 8'h00, 8'h00));
    vecs.push_back(mk("t5_idle",       0, 1, 0, 0, 0,   1,  0, 0, 0,  0, 8'h00, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Full run traced cycle by cycle against a time-based model of the countdown.
    bus.i_start_clean = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start_clean = 1'b0;
    for (int k = 0; k < 266; k++) begin
      if (k < 260) begin
        bcd = toBcd(CLEAN_SEC - k / CLK_HZ);
        cmp($sformatf("run_k%0d.remain", k), 32'(bus.o_remain_sec), 32'(CLEAN_SEC - k / CLK_HZ));
        cmp($sformatf("run_k%0d.bcd", k), {16'h0, bus.o_cd_min_bcd, bus.o_cd_sec_bcd}, {16'h0, bcd});
        cmp($sformatf("run_k%0d.cleaning", k), 32'(bus.o_cleaning), 32'd1);
      end else begin
        cmp($sformatf("run_k%0d.remain", k), 32'(bus.o_remain_sec), 32'd0);
        cmp($sformatf("run_k%0d.cleaning", k), 32'(bus.o_cleaning), 32'd0);
      end
      cmp($sformatf("run_k%0d.done", k), 32'(bus.o_done), (k == 260) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
